uart_rx_buffer: RTL

Receive-side frame buffer placed directly downstream of the UART receiver. Captures each completed frame (parallel data plus parity/framing error flags) on the rising edge of the receiver's data-valid indication and stores it in a tagged FIFO. Presents frames to the system controller over a valid/ready handshake, with occupancy, full/empty and sticky overflow status.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/rx_buf_mem.sv | 23 ++
 rtl/uart_rx_buffer.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared widths and entry layout for the UART receive buffer.
// Entry layout is {frm_err, par_err, data}.
package uart_rx_pkg;

  localparam int RX_DATA_W = 8;
  localparam int RX_DEPTH  = 8;
  localparam int ENTRY_W   = RX_DATA_W + 2;
  localparam int PTR_W     = $clog2(RX_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic                 frm_err;
    logic                 par_err;
    logic [RX_DATA_W-1:0] data;
  } rx_entry_t;

  function automatic int entry_w(int data_w);
    return data_w + 2;
  endfunction

  function automatic int ptr_w(int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rx_buf_mem.sv
// rx_buf_mem: DEPTH x W register array, synchronous write,
// combinational read, storage is not reset.
module rx_buf_mem #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: tagged receive FIFO behind the UART receiver.
// Optional UART_RX_DROP_ERR_EN discards error frames and counts them.
module uart_rx_buffer
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DATA_W,
  parameter int DEPTH      = RX_DEPTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_DATA_VALID,
  input  logic                      RX_PAR_ERR,
  input  logic                      RX_FRM_ERR,
  output logic [DATA_WIDTH-1:0]     OUT_DATA,
  output logic                      OUT_PAR_ERR,
  output logic                      OUT_FRM_ERR,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [cnt_w(DEPTH)-1:0]   COUNT,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic                      OVERFLOW,
`ifdef UART_RX_DROP_ERR_EN
  output logic [7:0]                ERR_DROP_CNT,
`endif
  input  logic                      CLR_OVF
);

  localparam int EW = entry_w(DATA_WIDTH);
  localparam int AW = ptr_w(DEPTH);
  localparam int NW = cnt_w(DEPTH);

  logic          vld_q;
  logic          armed;
  logic          cap;
  logic          cap_ok;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          ovf;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] cnt;
  logic [EW-1:0] rd_entry;

  // armed blocks a capture on the first cycle after reset,
  // so a valid level held through reset is never taken as a frame
  assign cap = RX_DATA_VALID & ~vld_q & armed;

`ifdef UART_RX_DROP_ERR_EN
  logic rx_err;
  assign rx_err = RX_PAR_ERR | RX_FRM_ERR;
  assign cap_ok = cap & ~rx_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_DROP_CNT <= '0;
    end else if (cap & rx_err & (ERR_DROP_CNT != 8'hFF)) begin
      ERR_DROP_CNT <= ERR_DROP_CNT + 8'd1;
    end
  end
`else
  assign cap_ok = cap;
`endif

  assign EMPTY     = (cnt == '0);
  assign FULL      = (cnt == NW'(DEPTH));
  assign OUT_VALID = ~EMPTY;
  assign COUNT     = cnt;
  assign OVERFLOW  = ovf;

  assign pop     = OUT_VALID & OUT_READY;
  assign push    = cap_ok & (~FULL | pop);
  assign ovf_set = cap_ok & FULL & ~pop;

  assign {OUT_FRM_ERR, OUT_PAR_ERR, OUT_DATA} =
    EMPTY ? '0 : rd_entry;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q  <= 1'b0;
      armed  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      vld_q <= RX_DATA_VALID;
      armed <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + NW'(1);
        2'b01:   cnt <= cnt - NW'(1);
        default: cnt <= cnt;
      endcase
      ovf <= ovf_set | (ovf & ~CLR_OVF);
    end
  end

  rx_buf_mem #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({RX_FRM_ERR, RX_PAR_ERR, RX_P_DATA}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

endmodule
